// File: rtl/qsfp_sideband_pkg.sv
// Shared QSFP sideband definitions: module-state encodings and pin reset levels.
package qsfp_sideband_pkg;

  typedef enum logic [1:0] {
    StAbsent = 2'd0,
    StReset  = 2'd1,
    StInit   = 2'd2,
    StReady  = 2'd3
  } emu_state_e;

  localparam logic ModselRst = 1'b1;
  localparam logic ResetlRst = 1'b1;
  localparam logic LpmodeRst = 1'b0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/qsfp_sync.sv
// N-flop input synchroniser with a configurable reset level.
module qsfp_sync #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {Stages{RstVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/qsfp_module_sideband_emu.sv
// Module-end QSFP low-speed sideband emulator: presence, reset detect, t_init, latched INTL.
// Optional: QSFP_EMU_INT_ON_LPMODE_EN makes LPMODE edges in READY raise the interrupt.
module qsfp_module_sideband_emu
  import qsfp_sideband_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned RESET_MIN_CYC = 16,
  parameter int unsigned INIT_CYC      = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       present_i,
  input  logic       fault_i,
  input  logic       int_clr_i,
  input  logic       QSFP_MODSELL_LS,
  input  logic       QSFP_RESETL_LS,
  input  logic       QSFP_LPMODE_LS,
  output logic       QSFP_MODPRSL_LS,
  output logic       QSFP_INTL_LS,
  output logic [1:0] state_o,
  output logic       lpmode_o,
  output logic [7:0] reset_count_o
);

  logic modsell_s, resetl_s, lpmode_s;

  qsfp_sync #(.Stages(SYNC_STAGES), .RstVal(ModselRst)) u_sync_modsell (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (QSFP_MODSELL_LS),
    .q_o   (modsell_s)
  );

  qsfp_sync #(.Stages(SYNC_STAGES), .RstVal(ResetlRst)) u_sync_resetl (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (QSFP_RESETL_LS),
    .q_o   (resetl_s)
  );

  qsfp_sync #(.Stages(SYNC_STAGES), .RstVal(LpmodeRst)) u_sync_lpmode (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (QSFP_LPMODE_LS),
    .q_o   (lpmode_s)
  );

  emu_state_e       state_q, state_d;
  logic             present_q;
  logic             latch_q, latch_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic             modprsl_q, intl_q;
  logic             reset_hit, int_set, int_clr, lp_edge;

`ifdef QSFP_EMU_INT_ON_LPMODE_EN
  logic lpmode_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lpmode_prev_q <= LpmodeRst;
    end else begin
      lpmode_prev_q <= lpmode_s;
    end
  end

  assign lp_edge = lpmode_s ^ lpmode_prev_q;
`else
  assign lp_edge = 1'b0;
`endif

  assign int_set = fault_i | lp_edge;
  assign int_clr = int_clr_i & ~modsell_s;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    latch_d    = latch_q;
    rst_cnt_d  = rst_cnt_q;
    // Saturating run-length of synced RESETL low
    if (resetl_s) begin
      low_cnt_d = '0;
    end else if (low_cnt_q == '1) begin
      low_cnt_d = low_cnt_q;
    end else begin
      low_cnt_d = low_cnt_q + CNT_W'(1);
    end
    reset_hit = (low_cnt_d >= CNT_W'(RESET_MIN_CYC));

    if (!present_i) begin
      state_d    = StAbsent;
      init_cnt_d = '0;
      low_cnt_d  = '0;
      latch_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAbsent: begin
          state_d    = StInit;
          init_cnt_d = '0;
          low_cnt_d  = '0;
        end
        StReset: begin
          if (resetl_s) begin
            state_d    = StInit;
            init_cnt_d = '0;
          end
        end
        StInit: begin
          if (reset_hit) begin
            state_d   = StReset;
            latch_d   = 1'b0;
            rst_cnt_d = sat_inc8(rst_cnt_q);
          end else if (init_cnt_q == CNT_W'(INIT_CYC - 1)) begin
            state_d = StReady;
            latch_d = 1'b1;
          end else begin
            init_cnt_d = init_cnt_q + CNT_W'(1);
          end
        end
        StReady: begin
          if (reset_hit) begin
            state_d   = StReset;
            latch_d   = 1'b0;
            rst_cnt_d = sat_inc8(rst_cnt_q);
          end else if (int_set) begin
            latch_d = 1'b1;
          end else if (int_clr) begin
            latch_d = 1'b0;
          end
        end
        default: state_d = StAbsent;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAbsent;
      present_q  <= 1'b0;
      latch_q    <= 1'b0;
      init_cnt_q <= '0;
      low_cnt_q  <= '0;
      rst_cnt_q  <= '0;
      modprsl_q  <= 1'b1;
      intl_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      present_q  <= present_i;
      latch_q    <= latch_d;
      init_cnt_q <= init_cnt_d;
      low_cnt_q  <= low_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      // Pins lag the state/latch registers by one cycle
      modprsl_q  <= ~present_q;
      intl_q     <= ~(latch_q & present_q);
    end
  end

  assign QSFP_MODPRSL_LS = modprsl_q;
  assign QSFP_INTL_LS    = intl_q;
  assign state_o         = state_q;
  assign lpmode_o        = lpmode_s & (state_q != StAbsent);
  assign reset_count_o   = rst_cnt_q;

endmodule

// File: tb/tb_qsfp_module_sideband_emu.sv
// Directed + randomized bench for the QSFP sideband emulator against a cycle model.
module tb_qsfp_module_sideband_emu;

  localparam int SYNC = 2;
  localparam int RMIN = 4;
  localparam int ICYC = 10;
  localparam int ABS = 0, RST = 1, INI = 2, RDY = 3;

  logic       clk, rst_n;
  logic       present, fault, clr, modsell, resetl, lpmode;
  logic       modprsl, intl, lpmode_o;
  logic [1:0] state;
  logic [7:0] rcnt;

  int vectors = 0;
  int miscompares = 0;

  qsfp_module_sideband_emu #(
    .SYNC_STAGES   (SYNC),
    .RESET_MIN_CYC (RMIN),
    .INIT_CYC      (ICYC),
    .CNT_W         (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .present_i       (present),
    .fault_i         (fault),
    .int_clr_i       (clr),
    .QSFP_MODSELL_LS (modsell),
    .QSFP_RESETL_LS  (resetl),
    .QSFP_LPMODE_LS  (lpmode),
    .QSFP_MODPRSL_LS (modprsl),
    .QSFP_INTL_LS    (intl),
    .state_o         (state),
    .lpmode_o        (lpmode_o),
    .reset_count_o   (rcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  int m_state, m_init, m_low, m_rcnt;
  bit m_present, m_latch, m_modprsl, m_intl, m_lprev;
  bit hm[SYNC];
  bit hr[SYNC];
  bit hl[SYNC];

  task automatic model_reset();
    m_state = ABS; m_init = 0; m_low = 0; m_rcnt = 0;
    m_present = 0; m_latch = 0; m_modprsl = 1; m_intl = 1; m_lprev = 0;
    for (int i = 0; i < SYNC; i++) begin
      hm[i] = 1; hr[i] = 1; hl[i] = 0;
    end
  endtask

  task automatic model_step();
    bit ms, rs, ls, edge_seen, hit;
    int low;
    ms = hm[SYNC-1];
    rs = hr[SYNC-1];
    ls = hl[SYNC-1];
    m_modprsl = !m_present;
    m_intl    = !(m_latch && m_present);
    m_present = present;
    low = rs ? 0 : ((m_low < 65535) ? m_low + 1 : m_low);
    hit = (low >= RMIN);
    edge_seen = 0;
`ifdef QSFP_EMU_INT_ON_LPMODE_EN
    edge_seen = (ls != m_lprev);
`endif
    m_lprev = ls;
    if (!present) begin
      m_state = ABS; m_init = 0; low = 0; m_latch = 0;
    end else if (m_state == ABS) begin
      m_state = INI; m_init = 0; low = 0;
    end else if (m_state == RST) begin
      if (rs) begin
        m_state = INI; m_init = 0;
      end
    end else if (hit) begin
      m_state = RST; m_latch = 0;
      if (m_rcnt < 255) m_rcnt++;
    end else if (m_state == INI) begin
      if (m_init == ICYC - 1) begin
        m_state = RDY; m_latch = 1;
      end else begin
        m_init++;
      end
    end else begin
      if (fault || edge_seen) m_latch = 1;
      else if (clr && !ms) m_latch = 0;
    end
    m_low = low;
    for (int i = SYNC - 1; i > 0; i--) begin
      hm[i] = hm[i-1]; hr[i] = hr[i-1]; hl[i] = hl[i-1];
    end
    hm[0] = modsell; hr[0] = resetl; hl[0] = lpmode;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    cmp("state", {6'd0, state}, 8'(m_state));
    cmp("modprsl", {7'd0, modprsl}, {7'd0, m_modprsl});
    cmp("intl", {7'd0, intl}, {7'd0, m_intl});
    cmp("lpmode_o", {7'd0, lpmode_o}, {7'd0, hl[SYNC-1] && (m_state != ABS)});
    cmp("reset_count", rcnt, 8'(m_rcnt));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
    end
  endtask

  initial begin
    rst_n = 1'b1;
    present = 0; fault = 0; clr = 0; modsell = 1; resetl = 1; lpmode = 0;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    tick(2);

    // Power-up: INIT entry, then READY and INTL after t_init
    present = 1;
    tick();
    cmp("init_entry_state", {6'd0, state}, 8'd2);
    tick();
    cmp("modprsl_low", {7'd0, modprsl}, 8'd0);
    tick(8);
    cmp("init_still", {6'd0, state}, 8'd2);
    tick();
    cmp("ready_after_tinit", {6'd0, state}, 8'd3);
    tick();
    cmp("intl_data_ready", {7'd0, intl}, 8'd0);

    // Clear ignored while deselected, honoured when selected
    clr = 1; tick(); clr = 0; tick(2);
    cmp("clr_deselected", {7'd0, intl}, 8'd0);
    modsell = 0; tick(2);
    clr = 1; tick(); clr = 0; tick();
    cmp("clr_selected", {7'd0, intl}, 8'd1);

    // Set beats clear
    fault = 1; clr = 1; tick(); fault = 0; clr = 0; tick();
    cmp("set_wins", {7'd0, intl}, 8'd0);

    // Short RESETL glitch ignored, long one recognised
    resetl = 0; tick(3); resetl = 1; tick(5);
    cmp("glitch_state", {6'd0, state}, 8'd3);
    cmp("glitch_count", rcnt, 8'd0);
    resetl = 0; tick(6);
    cmp("reset_state", {6'd0, state}, 8'd1);
    cmp("reset_count1", rcnt, 8'd1);
    resetl = 1; tick();
    cmp("reset_intl", {7'd0, intl}, 8'd1);
    tick(2);
    cmp("reinit_state", {6'd0, state}, 8'd2);
    tick(10);
    cmp("reready_state", {6'd0, state}, 8'd3);

    // Removal mid-INIT
    resetl = 0; tick(6); resetl = 1; tick(3); tick(4);
    present = 0; tick();
    cmp("removed_state", {6'd0, state}, 8'd0);
    tick();
    cmp("removed_modprsl", {7'd0, modprsl}, 8'd1);
    cmp("removed_intl", {7'd0, intl}, 8'd1);

    // Async reset mid-INIT, then full t_init again
    present = 1; tick(6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
    tick();
    cmp("post_rst_init", {6'd0, state}, 8'd2);
    tick(9);
    cmp("post_rst_not_ready", {6'd0, state}, 8'd2);
    tick();
    cmp("post_rst_ready", {6'd0, state}, 8'd3);

    // LPMODE in READY with latch cleared
    clr = 1; tick(); clr = 0; tick(2);
    cmp("lp_pre_intl", {7'd0, intl}, 8'd1);
    lpmode = 1; tick(4);
`ifdef QSFP_EMU_INT_ON_LPMODE_EN
    cmp("lp_intl", {7'd0, intl}, 8'd0);
`else
    cmp("lp_intl", {7'd0, intl}, 8'd1);
`endif
    cmp("lp_reflect", {7'd0, lpmode_o}, 8'd1);

    // Counter saturation
    for (int r = 0; r < 300; r++) begin
      resetl = 0; tick(6); resetl = 1; tick(3);
    end
    cmp("count_sat", rcnt, 8'd255);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) present = ~present;
      if ($urandom_range(9) == 0) resetl = ~resetl;
      if ($urandom_range(3) == 0) modsell = ~modsell;
      if ($urandom_range(15) == 0) lpmode = ~lpmode;
      fault = ($urandom_range(15) == 0);
      clr   = ($urandom_range(3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
